// File: rtl/ac97_pkg.sv
// Shared types and constants for the AC97 playback scheduler: state encoding,
// PCM sample width, underrun counter width and the optional attenuation helper.
package ac97_pkg;

   localparam int PCM_W      = 16;
   localparam int UNDERRUN_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_PLAY  = 2'd2,
      ST_MUTE  = 2'd3
   } play_state_t;

   // Arithmetic right shift keeps the sign of the two's-complement sample.
   function automatic logic [PCM_W-1:0] atten_shift(input logic [PCM_W-1:0] sample,
                                                    input logic [3:0]       shift);
      return PCM_W'($signed(sample) >>> shift);
   endfunction

endpackage

// File: rtl/ac97_pair_fifo.sv
// Stereo-pair FIFO ({left, right} per 32-bit entry) with occupancy count and
// a synchronous flush; DEPTH must be a power of two so pointers wrap naturally.
module ac97_pair_fifo #(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        flush,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head is read combinationally so a pop lands on the link register the
   // cycle after the frame strobe without a prefetch stage.
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push && !srst && !flush)
         mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ac97_play_sched.sv
// AC97 playback scheduler: primes a pair FIFO, pops one pair per frame strobe,
// mutes and counts underruns. Define AC97_PLAY_SCHED_VOLUME_EN for the Atten port.
module ac97_play_sched
   import ac97_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                  ClkIn,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic                  Dec_Valid,
   input  logic [PCM_W-1:0]      Dec_Left,
   input  logic [PCM_W-1:0]      Dec_Right,
   output logic                  Dec_Ready,
   input  logic                  New_Frame,
   output logic [PCM_W-1:0]      PCM_Playback_Left,
   output logic [PCM_W-1:0]      PCM_Playback_Right,
   output logic [UNDERRUN_W-1:0] Underrun_Cnt,
   output logic [1:0]            State
`ifdef AC97_PLAY_SCHED_VOLUME_EN
   ,
   input  logic [3:0]            Atten
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LEVEL);

   play_state_t           state_reg;
   logic [PCM_W-1:0]      pcm_left_reg;
   logic [PCM_W-1:0]      pcm_right_reg;
   logic [UNDERRUN_W-1:0] underrun_reg;

   logic          fifo_flush;
   logic          fifo_push;
   logic          fifo_pop;
   logic [31:0]   fifo_rd;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [PCM_W-1:0] pop_left;
   logic [PCM_W-1:0] pop_right;

   assign Dec_Ready  = Enable && (state_reg != ST_IDLE) && !fifo_full;
   assign fifo_push  = Dec_Valid && Dec_Ready;
   assign fifo_pop   = Enable && (state_reg == ST_PLAY) && New_Frame && !fifo_empty;
   assign fifo_flush = !Enable || (state_reg == ST_IDLE);

`ifdef AC97_PLAY_SCHED_VOLUME_EN
   assign pop_left  = atten_shift(fifo_rd[31:16], Atten);
   assign pop_right = atten_shift(fifo_rd[15:0], Atten);
`else
   assign pop_left  = fifo_rd[31:16];
   assign pop_right = fifo_rd[15:0];
`endif

   ac97_pair_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (ClkIn),
      .srst    (Reset),
      .flush   (fifo_flush),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data ({Dec_Left, Dec_Right}),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge ClkIn) begin
      if (Reset) begin
         state_reg     <= ST_IDLE;
         pcm_left_reg  <= '0;
         pcm_right_reg <= '0;
         underrun_reg  <= '0;
      end else if (!Enable) begin
         state_reg     <= ST_IDLE;
         pcm_left_reg  <= '0;
         pcm_right_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               pcm_left_reg  <= '0;
               pcm_right_reg <= '0;
               state_reg     <= ST_PRIME;
            end
            ST_PRIME, ST_MUTE: begin
               pcm_left_reg  <= '0;
               pcm_right_reg <= '0;
               if (fifo_count >= PRIME_CNT)
                  state_reg <= ST_PLAY;
            end
            ST_PLAY: begin
               // Outputs hold between strobes; an empty FIFO at a strobe mutes.
               if (New_Frame) begin
                  if (!fifo_empty) begin
                     pcm_left_reg  <= pop_left;
                     pcm_right_reg <= pop_right;
                  end else begin
                     pcm_left_reg  <= '0;
                     pcm_right_reg <= '0;
                     if (underrun_reg != '1)
                        underrun_reg <= underrun_reg + UNDERRUN_W'(1);
                     state_reg <= ST_MUTE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign PCM_Playback_Left  = pcm_left_reg;
   assign PCM_Playback_Right = pcm_right_reg;
   assign Underrun_Cnt       = underrun_reg;
   assign State              = state_reg;

endmodule

// File: tb/tb_ac97_play_sched.sv
// Directed bench for ac97_play_sched: priming, per-frame pops, underrun/mute,
// full-FIFO push/pop overlap, Enable drop, mid-play reset and optional attenuation.
module tb_ac97_play_sched;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        dec_valid;
   logic [15:0] dec_left;
   logic [15:0] dec_right;
   logic        dec_ready;
   logic        new_frame;
   logic [15:0] pcm_left;
   logic [15:0] pcm_right;
   logic [7:0]  underrun_cnt;
   logic [1:0]  state;
`ifdef AC97_PLAY_SCHED_VOLUME_EN
   logic [3:0]  atten;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pair;

   ac97_play_sched #(
      .FIFO_DEPTH  (8),
      .PRIME_LEVEL (4)
   ) dut (
      .ClkIn              (clk),
      .Reset              (reset),
      .Enable             (enable),
      .Dec_Valid          (dec_valid),
      .Dec_Left           (dec_left),
      .Dec_Right          (dec_right),
      .Dec_Ready          (dec_ready),
      .New_Frame          (new_frame),
      .PCM_Playback_Left  (pcm_left),
      .PCM_Playback_Right (pcm_right),
      .Underrun_Cnt       (underrun_cnt),
      .State              (state)
`ifdef AC97_PLAY_SCHED_VOLUME_EN
      ,
      .Atten              (atten)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pair_val(input int k);
      logic [7:0] a;
      logic [7:0] b;
      a = 8'(2 * k - 1);
      b = 8'(2 * k);
      return {a, a, b, b};
   endfunction

   task automatic push_pair(input logic [31:0] p);
      dec_valid = 1'b1;
      dec_left  = p[31:16];
      dec_right = p[15:0];
      exp_q.push_back(p);
      tick();
      dec_valid = 1'b0;
   endtask

   task automatic frame();
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
   endtask

   task automatic frame_expect(input string tag);
      frame();
      exp_pair = exp_q.pop_front();
      check({tag, "_left"},  {16'h0, pcm_left},  {16'h0, exp_pair[31:16]});
      check({tag, "_right"}, {16'h0, pcm_right}, {16'h0, exp_pair[15:0]});
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      dec_valid = 1'b0;
      dec_left  = '0;
      dec_right = '0;
      new_frame = 1'b0;
`ifdef AC97_PLAY_SCHED_VOLUME_EN
      atten     = 4'd0;
`endif
      tick();
      tick();
      check("rst_state", {30'h0, state}, 32'd0);
      check("rst_left", {16'h0, pcm_left}, 32'd0);
      check("rst_underrun", {24'h0, underrun_cnt}, 32'd0);
      check("rst_ready", {31'h0, dec_ready}, 32'd0);

      // Enable: IDLE -> PRIME, then prime with four pairs
      reset  = 1'b0;
      enable = 1'b1;
      tick();
      check("prime_state", {30'h0, state}, 32'd1);
      check("prime_ready", {31'h0, dec_ready}, 32'd1);
      for (int k = 1; k <= 3; k++) push_pair(pair_val(k));
      check("prime3_state", {30'h0, state}, 32'd1);
      push_pair(pair_val(4));
      tick();
      check("play_state", {30'h0, state}, 32'd2);
      check("play_prepop_left", {16'h0, pcm_left}, 32'd0);

      // First pop, one cycle after the strobe, then hold
      frame();
      check("pop1_left", {16'h0, pcm_left}, 32'h0101);
      check("pop1_right", {16'h0, pcm_right}, 32'h0202);
      void'(exp_q.pop_front());
      tick();
      check("hold_left", {16'h0, pcm_left}, 32'h0101);

      // Drain, then underrun
      for (int k = 2; k <= 4; k++) frame_expect($sformatf("drain%0d", k));
      frame();
      check("underrun_left", {16'h0, pcm_left}, 32'd0);
      check("underrun_right", {16'h0, pcm_right}, 32'd0);
      check("underrun_cnt", {24'h0, underrun_cnt}, 32'd1);
      check("mute_state", {30'h0, state}, 32'd3);
      tick();

      // Re-prime from MUTE
      for (int k = 5; k <= 8; k++) push_pair(pair_val(k));
      tick();
      check("remute_play_state", {30'h0, state}, 32'd2);
      check("remute_left", {16'h0, pcm_left}, 32'd0);

      // Fill to 8 pairs
      for (int k = 9; k <= 12; k++) push_pair(pair_val(k));
      check("full_ready", {31'h0, dec_ready}, 32'd0);

      // Strobe and valid together while full: pop now, push next cycle
      dec_valid = 1'b1;
      dec_left  = pair_val(13)[31:16];
      dec_right = pair_val(13)[15:0];
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      check("ovl_pop_left", {16'h0, pcm_left}, 32'h0909);
      check("ovl_ready", {31'h0, dec_ready}, 32'd1);
      void'(exp_q.pop_front());
      exp_q.push_back(pair_val(13));
      tick();
      dec_valid = 1'b0;
      check("ovl_full_again", {31'h0, dec_ready}, 32'd0);

      // Pop three to leave five buffered, then drop Enable
      for (int k = 6; k <= 8; k++) frame_expect($sformatf("pop%0d", k));
      enable = 1'b0;
      tick();
      check("dis_state", {30'h0, state}, 32'd0);
      check("dis_left", {16'h0, pcm_left}, 32'd0);
      check("dis_right", {16'h0, pcm_right}, 32'd0);
      check("dis_ready", {31'h0, dec_ready}, 32'd0);
      check("dis_underrun", {24'h0, underrun_cnt}, 32'd1);
      exp_q.delete();

      // Re-enable: three pushes must not reach PLAY (FIFO was flushed)
      enable = 1'b1;
      tick();
`ifdef AC97_PLAY_SCHED_VOLUME_EN
      atten = 4'd2;
`endif
      push_pair({16'h8000, 16'h4000});
      push_pair({16'h7FFC, 16'hFFF0});
      push_pair(pair_val(20));
      tick();
      check("flush_state", {30'h0, state}, 32'd1);
      push_pair(pair_val(21));
      tick();
      check("reen_play_state", {30'h0, state}, 32'd2);
      frame();
`ifdef AC97_PLAY_SCHED_VOLUME_EN
      check("vol_left", {16'h0, pcm_left}, 32'hE000);
      check("vol_right", {16'h0, pcm_right}, 32'h1000);
`else
      check("pass_left", {16'h0, pcm_left}, 32'h8000);
      check("pass_right", {16'h0, pcm_right}, 32'h4000);
`endif
      tick();
      frame();
`ifdef AC97_PLAY_SCHED_VOLUME_EN
      check("vol2_left", {16'h0, pcm_left}, 32'h1FFF);
      check("vol2_right", {16'h0, pcm_right}, 32'hFFFC);
      atten = 4'd0;
`else
      check("pass2_left", {16'h0, pcm_left}, 32'h7FFC);
      check("pass2_right", {16'h0, pcm_right}, 32'hFFF0);
`endif
      tick();
      exp_q.delete();

      // Reset mid-playback with pairs still buffered
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_state", {30'h0, state}, 32'd0);
      check("mid_rst_left", {16'h0, pcm_left}, 32'd0);
      check("mid_rst_underrun", {24'h0, underrun_cnt}, 32'd0);
      check("mid_rst_ready", {31'h0, dec_ready}, 32'd0);
      tick();
      push_pair({16'h1111, 16'h2222});
      for (int k = 30; k <= 32; k++) push_pair(pair_val(k));
      tick();
      check("post_rst_state", {30'h0, state}, 32'd2);
      frame_expect("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ac97_play_sched.md
AC97_PLAY_SCHED -- requirements
Module: ac97_play_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, stereo-pair buffer depth; power of two, 4..64.
REQ-002 SHALL have parameter PRIME_LEVEL, default 4, pairs buffered before playback starts; 1..FIFO_DEPTH.
REQ-003 SHALL have port ClkIn, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Enable, input, 1, playback enable from the player control.
REQ-006 SHALL have port Dec_Valid, input, 1, decoder sample pair valid.
REQ-007 SHALL have ports Dec_Left and Dec_Right, input, 16 each, signed decoder PCM.
REQ-008 SHALL have port Dec_Ready, output, 1, high when the FIFO can accept a pair.
REQ-009 SHALL have port New_Frame, input, 1, one-cycle AC97 frame strobe, synchronous to ClkIn.
REQ-010 SHALL have ports PCM_Playback_Left and PCM_Playback_Right, output, 16 each, to the AC97 link.
REQ-011 SHALL have port Underrun_Cnt, output, 8, saturating underrun counter.
REQ-012 SHALL have port State, output, 2, current FSM state encoding.

Function
REQ-013 SHALL buffer pairs in a FIFO_DEPTH-entry, 32-bit FIFO with log2(FIFO_DEPTH)+1-bit occupancy count; pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL drive Dec_Ready = (count != FIFO_DEPTH) and Enable; a push occurs on Dec_Valid and Dec_Ready.
REQ-015 SHALL implement states IDLE=0, PRIME=1, PLAY=2, MUTE=3.
REQ-016 IDLE: outputs zero, FIFO flushed, Dec_Ready low; Enable high -> PRIME next cycle.
REQ-017 PRIME: accept pushes, outputs zero; count >= PRIME_LEVEL -> PLAY.
REQ-018 PLAY: on New_Frame with count != 0, pop head and register it onto PCM_Playback_Left/Right one cycle after the strobe; hold until next pop.
REQ-019 PLAY: on New_Frame with count == 0, drive zero outputs one cycle later, increment Underrun_Cnt (saturate at 255), go MUTE.
REQ-020 MUTE: outputs zero; count >= PRIME_LEVEL -> PLAY; next pop at the following New_Frame.
REQ-021 Simultaneous push and pop SHALL change count by zero; push while full SHALL not occur (Dec_Ready low).
REQ-022 Enable low in any state SHALL go to IDLE next cycle, flush FIFO, zero PCM outputs; Underrun_Cnt retained.
REQ-023 New_Frame outside PLAY SHALL not pop.

Reset
REQ-024 Reset SHALL be synchronous, active-high, and override all other inputs.
REQ-025 On Reset: State=IDLE, count/pointers=0, PCM outputs=0, Underrun_Cnt=0, Dec_Ready=0.
REQ-026 Reset mid-playback SHALL discard buffered pairs; no partial sample is output after reset.

Configuration
REQ-027 Macro AC97_PLAY_SCHED_VOLUME_EN compiled in SHALL add input Atten (4-bit) and arithmetic-right-shift popped samples by Atten (sign-preserving, Atten>15 impossible) before registering outputs.
REQ-028 Without AC97_PLAY_SCHED_VOLUME_EN, no Atten port exists and popped samples pass unmodified.

Structure
REQ-029 Shared package ac97_pkg SHALL hold the state encoding constants, PCM width (16), and underrun counter width (8).
REQ-030 FIFO SHALL be a sub-module ac97_pair_fifo (push, pop, full, empty, count); the FSM and output registers stay in ac97_play_sched.

Verification
REQ-031 Reset, Enable=1, push 4 pairs (0x0101/0x0202..) -> State PRIME then PLAY after 4th push; outputs stay 0 until first New_Frame.
REQ-032 In PLAY, New_Frame pulse -> PCM_Playback_Left=0x0101, Right=0x0202 exactly one cycle later; count drops by 1.
REQ-033 Drain FIFO, then New_Frame with count 0 -> outputs 0x0000, Underrun_Cnt=1, State MUTE; push 4 pairs -> PLAY.
REQ-034 Fill 8 pairs -> Dec_Ready low; New_Frame and Dec_Valid same cycle -> pop and push accepted next cycle, count remains 8 after.
REQ-035 Enable dropped with 5 pairs buffered -> State IDLE next cycle, count 0, outputs 0; Underrun_Cnt unchanged.
REQ-036 With VOLUME_EN, Atten=2, popped 0x8000 -> output 0xE000; 0x4000 -> 0x1000.
